// File: rtl/sample_dump_pkg.sv
// Shared definitions for the sample capture / dump controller.
package sample_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLING,
    ST_READ,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  localparam logic [7:0] CMD_START_DEFAULT = 8'h53;
  localparam logic [7:0] CMD_ABORT_DEFAULT = 8'h41;

endpackage

// File: rtl/sample_dump_ctrl_addr_counter.sv
// Modulo-2**ADDR_W address counter with synchronous clear and terminal-count flag.
module addr_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iClear,
  input  logic              iInc,
  output logic [ADDR_W-1:0] oCount,
  output logic              oTermCount
);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge iClock) begin
    if (iReset || iClear) begin
      oCount <= '0;
    end else if (iInc) begin
      oCount <= oCount + 1'b1;
    end
  end

  assign oTermCount = &oCount;

endmodule

// File: rtl/sample_dump_ctrl.sv
// Captures 2**ADDR_W samples into an external RAM on a UART start command,
// then streams them back out through the UART transmitter in address order.
module sample_dump_ctrl
  import sample_dump_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  CMD_START = CMD_START_DEFAULT,
  parameter logic [7:0]  CMD_ABORT = CMD_ABORT_DEFAULT
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iRxDone,
  input  logic [7:0]        iRxData,
  input  logic              iSampleValid,
  input  logic [7:0]        iSample,
  input  logic [7:0]        iMemRData,
  input  logic              iTxDone,
  output logic              oMemWrite,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [7:0]        oMemWData,
  output logic              oTxStart,
  output logic [7:0]        oTxData,
  output logic              oBusy
);

  state_t              state;
  state_t              stateNext;
  logic [ADDR_W-1:0]   count;
  logic [ADDR_W-1:0]   countNext;
  logic                termCount;
  logic                cntClear;
  logic                cntInc;
  logic                startCmd;
  logic                abortCmd;
  logic                captureDone;
  logic                memWriteNext;
  logic [ADDR_W-1:0]   memAddrNext;
  logic [7:0]          memWDataNext;
  logic                txStartNext;
  logic [7:0]          txDataNext;

  assign startCmd    = iRxDone && (iRxData == CMD_START);
  assign abortCmd    = iRxDone && (iRxData == CMD_ABORT) && (state != ST_IDLE);
  // The last write is on the bus and the counter has already wrapped to 0.
  assign captureDone = oMemWrite && (count == '0);
  assign countNext   = count + 1'b1;
  assign oBusy       = (state != ST_IDLE);

  addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
    .iClock     (iClock),
    .iReset     (iReset),
    .iClear     (cntClear),
    .iInc       (cntInc),
    .oCount     (count),
    .oTermCount (termCount)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state     <= ST_IDLE;
      oMemWrite <= 1'b0;
      oMemAddr  <= '0;
      oMemWData <= '0;
      oTxStart  <= 1'b0;
      oTxData   <= '0;
    end else begin
      state     <= stateNext;
      oMemWrite <= memWriteNext;
      oMemAddr  <= memAddrNext;
      oMemWData <= memWDataNext;
      oTxStart  <= txStartNext;
      oTxData   <= txDataNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE:     if (startCmd) stateNext = ST_SAMPLING;
      ST_SAMPLING: if (captureDone) stateNext = ST_READ;
      ST_READ:     stateNext = ST_SEND;
      ST_SEND:     stateNext = ST_WAIT_TX;
      ST_WAIT_TX:  if (iTxDone) stateNext = termCount ? ST_IDLE : ST_READ;
      default:     stateNext = ST_IDLE;
    endcase
    if (abortCmd) stateNext = ST_IDLE;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cntClear     = 1'b0;
    cntInc       = 1'b0;
    memWriteNext = 1'b0;
    memAddrNext  = oMemAddr;
    memWDataNext = oMemWData;
    txStartNext  = 1'b0;
    txDataNext   = oTxData;
    if (!abortCmd) begin
      unique case (state)
        ST_IDLE: cntClear = startCmd;
        ST_SAMPLING: begin
          if (captureDone) begin
            memAddrNext = count;
          end else if (iSampleValid) begin
            memWriteNext = 1'b1;
            memAddrNext  = count;
            memWDataNext = iSample;
            cntInc       = 1'b1;
          end
        end
        ST_SEND: begin
          txStartNext = 1'b1;
          txDataNext  = iMemRData;
        end
        ST_WAIT_TX: begin
          if (iTxDone && !termCount) begin
            cntInc      = 1'b1;
            memAddrNext = countNext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sample_dump_ctrl.md
SAMPLE_DUMP_CTRL -- requirements
Module: sample_dump_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, sample-memory address width; depth = 2**ADDR_W.
REQ-002 Parameter CMD_START, default 8'h53, received byte that starts a capture.
REQ-003 Parameter CMD_ABORT, default 8'h41, received byte that aborts any operation.
REQ-004 iClock  in  1  system clock; all logic on rising edge.
REQ-005 iReset  in  1  reset, synchronous, active-high.
REQ-006 iRxDone  in  1  one-cycle pulse, UART byte received.
REQ-007 iRxData  in  8  received byte, valid when iRxDone=1.
REQ-008 iSampleValid  in  1  one-cycle strobe, new sample on iSample.
REQ-009 iSample  in  8  sample data.
REQ-010 iMemRData  in  8  memory read data, valid one cycle after oMemAddr is presented with oMemWrite=0.
REQ-011 iTxDone  in  1  one-cycle pulse, UART transmitter finished the current byte.
REQ-012 oMemWrite  out  1  memory write enable.
REQ-013 oMemAddr  out  ADDR_W  memory address.
REQ-014 oMemWData  out  8  memory write data.
REQ-015 oTxStart  out  1  one-cycle pulse, transmitter to send oTxData.
REQ-016 oTxData  out  8  byte to transmit, stable from the oTxStart cycle until iTxDone.
REQ-017 oBusy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, SAMPLING, READ, SEND, WAIT_TX; oMemWrite, oMemAddr, oMemWData, oTxStart, oTxData all registered.
REQ-019 IDLE: iRxDone with iRxData==CMD_START -> SAMPLING, address counter cleared to 0; any other byte ignored.
REQ-020 SAMPLING: each iSampleValid produces exactly one write (oMemWrite=1 for one cycle, oMemAddr=counter, oMemWData=iSample) on the following cycle, then counter increments.
REQ-021 SAMPLING: the write at address 2**ADDR_W-1 completes capture; counter wraps to 0 and FSM -> READ; no further samples written.
REQ-022 SAMPLING with no iSampleValid: wait indefinitely, outputs hold, oMemWrite=0.
REQ-023 READ: present oMemAddr=counter, oMemWrite=0, for one cycle; -> SEND.
REQ-024 SEND: latch iMemRData into oTxData, pulse oTxStart for one cycle; -> WAIT_TX.
REQ-025 WAIT_TX: on iTxDone, if counter==2**ADDR_W-1 -> IDLE, else increment counter -> READ.
REQ-026 Exactly 2**ADDR_W bytes sent per capture, in address order 0..2**ADDR_W-1.
REQ-027 iRxDone with iRxData==CMD_ABORT in any non-IDLE state -> IDLE next cycle; oMemWrite, oTxStart forced 0; abort wins over a simultaneous iSampleValid or iTxDone.
REQ-028 iRxDone with CMD_START or other bytes outside IDLE ignored (no restart).
REQ-029 iTxDone outside WAIT_TX ignored; iSampleValid outside SAMPLING ignored.
REQ-030 Address counter width ADDR_W, unsigned, modulo 2**ADDR_W.

Reset
REQ-031 iReset forces IDLE, counter=0, oMemWrite=0, oMemAddr=0, oMemWData=0, oTxStart=0, oTxData=0, oBusy=0 on the next edge.
REQ-032 iReset has priority over all inputs, including mid-capture or mid-transmit; no pending write or oTxStart issued afterward.

Structure
REQ-033 State encoding and CMD_START/CMD_ABORT defaults in shared package sample_dump_pkg.
REQ-034 Single module; address counter may be sub-module addr_counter (clear, increment, terminal-count flag).

Verification
REQ-035 ADDR_W=4; byte 8'h53, then 16 iSampleValid with samples 0x10..0x1F -> 16 writes addr 0..15, data 0x10..0x1F, then FSM in READ.
REQ-036 Memory model returns written data, iTxDone 5 cycles after each oTxStart -> 16 oTxStart pulses, oTxData 0x10..0x1F in order, then IDLE, oBusy=0.
REQ-037 In IDLE send byte 8'h00 and 8'h41 -> no state change, oBusy stays 0.
REQ-038 After 7 samples send 8'h41 on the same cycle as iSampleValid -> no 8th write, IDLE next cycle; new 8'h53 restarts at addr 0.
REQ-039 iReset asserted during WAIT_TX of byte 3 -> all outputs zero next cycle; following iTxDone produces no oTxStart.
REQ-040 Byte 8'h53 received during SEND phase -> ignored, transmission continues to 16 bytes.
